// File: rtl/memory_access.sv
// MIPS32 memory-access (M) stage: pipeline register, req/ack data-bus master,
// lane alignment for stores, load extraction/extension, misalignment and
// bus-timeout faults, and upstream stall generation.
module memory_access #(
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write_e,
  input  logic        mem_to_reg_e,
  input  logic        mem_write_e,
  input  logic [1:0]  mem_size_e,
  input  logic        mem_unsigned_e,
  input  logic [31:0] alu_out_e,
  input  logic [31:0] write_data_e,
  input  logic [4:0]  write_reg_e,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_m,
  output logic        reg_write_m,
  output logic        mem_to_reg_m,
  output logic [31:0] alu_out_m,
  output logic [31:0] read_data_m,
  output logic [4:0]  write_reg_m,
  output logic        fault_m
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam logic [DW-1:0] TO_LAST = (BUS_TIMEOUT == 0) ? 32'd0 : 32'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   count_q, count_d;
  logic [DW-1:0]   read_data_q, read_data_d;

  logic            reg_write_q;
  logic            mem_to_reg_q;
  logic            mem_write_q;
  logic [1:0]      mem_size_q;
  logic            mem_unsigned_q;
  logic [DW-1:0]   alu_out_q;
  logic [DW-1:0]   write_data_q;
  logic [RW-1:0]   write_reg_q;

  logic            mem_op;
  logic            aligned;
  logic            timeout_fire;
  logic [3:0]      be;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   load_val;
  logic            req_c;
  logic            stall_c;
  logic            fault_c;

  // Access decode: alignment, byte enables, replicated store data
  always_comb begin
    aligned = 1'b1;
    be      = 4'hF;
    wdata   = write_data_q;
    case (mem_size_q)
      2'b00: begin
        aligned = 1'b1;
        be      = 4'(4'b0001 << alu_out_q[1:0]);
        wdata   = {4{write_data_q[7:0]}};
      end
      2'b01: begin
        aligned = ~alu_out_q[0];
        be      = alu_out_q[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{write_data_q[15:0]}};
      end
      default: begin
        aligned = (alu_out_q[1:0] == 2'b00);
        be      = 4'hF;
        wdata   = write_data_q;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'h00;
    h = alu_out_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (alu_out_q[1:0])
      2'd0:    b = dmem_rdata[7:0];
      2'd1:    b = dmem_rdata[15:8];
      2'd2:    b = dmem_rdata[23:16];
      default: b = dmem_rdata[31:24];
    endcase
    case (mem_size_q)
      2'b00:   load_val = {{24{~mem_unsigned_q & b[7]}}, b};
      2'b01:   load_val = {{16{~mem_unsigned_q & h[15]}}, h};
      default: load_val = dmem_rdata;
    endcase
  end

  assign mem_op       = mem_to_reg_q | mem_write_q;
  assign timeout_fire = (BUS_TIMEOUT != 0) && (state_q == BUSY) && (count_q == TO_LAST);

  // Bus FSM next state, stall/fault/request and load capture
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    read_data_d = read_data_q;
    req_c       = 1'b0;
    stall_c     = 1'b0;
    fault_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (aligned) begin
            req_c   = 1'b1;
            stall_c = 1'b1;
            if (dmem_ack) begin
              state_d = DONE;
              if (mem_to_reg_q) read_data_d = load_val;
            end else begin
              state_d = BUSY;
              count_d = '0;
            end
          end else begin
            fault_c = 1'b1;
          end
        end
      end
      BUSY: begin
        if (timeout_fire) begin
          fault_c = 1'b1;
          state_d = IDLE;
        end else begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          if (dmem_ack) begin
            state_d = DONE;
            if (mem_to_reg_q) read_data_d = load_val;
          end else if (count_q != '1) begin
            count_d = count_q + 32'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Reset abandons any transfer in the same cycle
    if (rst) begin
      req_c   = 1'b0;
      stall_c = 1'b0;
      fault_c = 1'b0;
    end
  end

  // FSM state, timeout counter and load data register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      read_data_q <= read_data_d;
    end
  end

  // M pipeline register: loads from E unless the stage is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_size_q     <= 2'b00;
      mem_unsigned_q <= 1'b0;
      alu_out_q      <= '0;
      write_data_q   <= '0;
      write_reg_q    <= '0;
    end else if (!stall_c) begin
      reg_write_q    <= reg_write_e;
      mem_to_reg_q   <= mem_to_reg_e;
      mem_write_q    <= mem_write_e;
      mem_size_q     <= mem_size_e;
      mem_unsigned_q <= mem_unsigned_e;
      alu_out_q      <= alu_out_e;
      write_data_q   <= write_data_e;
      write_reg_q    <= write_reg_e;
    end
  end

  assign dmem_req     = req_c;
  assign dmem_we      = mem_write_q & ~rst;
  assign dmem_addr    = {alu_out_q[31:2], 2'b00};
  assign dmem_be      = req_c ? be : 4'b0000;
  assign dmem_wdata   = wdata;
  assign stall_m      = stall_c;
  assign fault_m      = fault_c;
  assign reg_write_m  = reg_write_q & ~stall_c & ~fault_c & ~rst;
  assign mem_to_reg_m = mem_to_reg_q;
  assign alu_out_m    = alu_out_q;
  assign read_data_m  = read_data_q;
  assign write_reg_m  = write_reg_q;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed cases then random
// instructions checked against a transaction-level model of the M stage.
module tb_memory_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_e, mem_to_reg_e, mem_write_e, mem_unsigned_e;
  logic [1:0]  mem_size_e;
  logic [31:0] alu_out_e, write_data_e;
  logic [4:0]  write_reg_e;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_m, reg_write_m, mem_to_reg_m, fault_m;
  logic [31:0] alu_out_m, read_data_m;
  logic [4:0]  write_reg_m;

  int          errs = 0;
  int          checks = 0;
  logic [31:0] exp_rd;

  memory_access #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .mem_size_e(mem_size_e), .mem_unsigned_e(mem_unsigned_e), .alu_out_e(alu_out_e),
    .write_data_e(write_data_e), .write_reg_e(write_reg_e),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_m(stall_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
    .alu_out_m(alu_out_m), .read_data_m(read_data_m), .write_reg_m(write_reg_m),
    .fault_m(fault_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_aligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b1;
    if (sz == 2'd1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    int lane;
    lane = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << lane);
    if (sz == 2'd1) return 4'(3 << lane);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] b, h;
    b = wd & 32'hFF;
    h = wd & 32'hFFFF;
    if (sz == 2'd0) return b * 32'h01010101;
    if (sz == 2'd1) return h * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input bit uns,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh, v;
    sh = rd >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = sh & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = sh & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic drive_e(input bit rw, input bit mtr, input bit mw, input logic [1:0] sz,
                         input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] wr);
    reg_write_e = rw; mem_to_reg_e = mtr; mem_write_e = mw; mem_size_e = sz;
    mem_unsigned_e = uns; alu_out_e = addr; write_data_e = wd; write_reg_e = wr;
  endtask

  // One instruction through M; ackd = cycles after issue until ack (>= TO: never)
  task automatic do_op(input string nm, input bit rw, input bit mtr, input bit mw,
                       input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] wr, input int ackd,
                       input logic [31:0] rdata);
    bit memop, al, done;
    memop = mtr | mw;
    al    = is_aligned(sz, addr);
    done  = 1'b0;
    drive_e(rw, mtr, mw, sz, uns, addr, wd, wr);
    @(posedge clk); #1;
    drive_e(0, 0, 0, 2'd0, 0, 32'd0, 32'd0, 5'd0);
    for (int k = 0; k < 12 && !done; k++) begin
      dmem_ack   = memop && al && (ackd < TO) && (k == ackd);
      dmem_rdata = (k == ackd) ? rdata : $urandom;
      @(negedge clk);
      if (!memop) begin
        chk({nm, ".alu_req"}, 32'(dmem_req), 32'd0);
        chk({nm, ".alu_stall"}, 32'(stall_m), 32'd0);
        chk({nm, ".alu_rw"}, 32'(reg_write_m), 32'(rw));
        chk({nm, ".alu_out"}, alu_out_m, addr);
        chk({nm, ".alu_wr"}, 32'(write_reg_m), 32'(wr));
        done = 1'b1;
      end else if (!al) begin
        chk({nm, ".mis_req"}, 32'(dmem_req), 32'd0);
        chk({nm, ".mis_fault"}, 32'(fault_m), 32'd1);
        chk({nm, ".mis_stall"}, 32'(stall_m), 32'd0);
        chk({nm, ".mis_rw"}, 32'(reg_write_m), 32'd0);
        done = 1'b1;
      end else if (ackd < TO && k == ackd + 1) begin
        if (mtr) exp_rd = exp_load(sz, uns, addr, rdata);
        chk({nm, ".done_stall"}, 32'(stall_m), 32'd0);
        chk({nm, ".done_req"}, 32'(dmem_req), 32'd0);
        chk({nm, ".done_rw"}, 32'(reg_write_m), 32'(rw));
        chk({nm, ".done_mtr"}, 32'(mem_to_reg_m), 32'(mtr));
        chk({nm, ".done_wr"}, 32'(write_reg_m), 32'(wr));
        chk({nm, ".done_rdata"}, read_data_m, exp_rd);
        done = 1'b1;
      end else if (ackd >= TO && k == TO) begin
        chk({nm, ".to_req"}, 32'(dmem_req), 32'd0);
        chk({nm, ".to_fault"}, 32'(fault_m), 32'd1);
        chk({nm, ".to_stall"}, 32'(stall_m), 32'd0);
        chk({nm, ".to_rw"}, 32'(reg_write_m), 32'd0);
        chk({nm, ".to_rdata"}, read_data_m, exp_rd);
        done = 1'b1;
      end else begin
        chk({nm, ".busy_req"}, 32'(dmem_req), 32'd1);
        chk({nm, ".busy_stall"}, 32'(stall_m), 32'd1);
        chk({nm, ".busy_rw"}, 32'(reg_write_m), 32'd0);
        chk({nm, ".busy_fault"}, 32'(fault_m), 32'd0);
        if (k == 0) begin
          chk({nm, ".addr"}, dmem_addr, addr & 32'hFFFFFFFC);
          chk({nm, ".be"}, 32'(dmem_be), 32'(exp_be(sz, addr)));
          chk({nm, ".we"}, 32'(dmem_we), 32'(mw));
          if (mw) chk({nm, ".wdata"}, dmem_wdata, exp_wdata(sz, wd));
        end
      end
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    chk({nm, ".completes"}, 32'(done), 32'd1);
  endtask

  initial begin
    bit          rw, mtr, mw, uns;
    logic [1:0]  sz;
    logic [31:0] a;
    int          ackd;

    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0; exp_rd = 32'd0;
    drive_e(0, 0, 0, 2'd0, 0, 32'd0, 32'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall_m), 32'd0);
    chk("rst_rw", 32'(reg_write_m), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_alu", alu_out_m, 32'd0);
    chk("post_rst_rdata", read_data_m, 32'd0);
    chk("post_rst_fault", 32'(fault_m), 32'd0);
    @(posedge clk); #1;

    do_op("alu", 1, 0, 0, 2'd2, 0, 32'h1234, 32'd0, 5'd5, 0, 32'd0);
    do_op("lw", 1, 1, 0, 2'd2, 0, 32'h100, 32'd0, 5'd6, 3, 32'hDEADBEEF);
    do_op("lb", 1, 1, 0, 2'd0, 0, 32'h103, 32'd0, 5'd7, 1, 32'h80123456);
    do_op("lbu", 1, 1, 0, 2'd0, 1, 32'h103, 32'd0, 5'd7, 0, 32'h80123456);
    do_op("lh", 1, 1, 0, 2'd1, 0, 32'h102, 32'd0, 5'd8, 2, 32'h80011234);
    do_op("sh", 0, 0, 1, 2'd1, 0, 32'h202, 32'h0000ABCD, 5'd0, 1, 32'hFFFFFFFF);
    do_op("lw_mis", 1, 1, 0, 2'd2, 0, 32'h101, 32'd0, 5'd9, 0, 32'd0);
    do_op("lw_to", 1, 1, 0, 2'd2, 0, 32'h104, 32'd0, 5'd9, TO, 32'd0);

    // Reset while the bus is busy
    drive_e(1, 1, 0, 2'd2, 0, 32'h300, 32'd0, 5'd9);
    @(posedge clk); #1;
    drive_e(0, 0, 0, 2'd0, 0, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("rb_issue_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rb_rst_req", 32'(dmem_req), 32'd0);
    chk("rb_rst_stall", 32'(stall_m), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D; exp_rd = 32'd0;
    @(negedge clk);
    chk("rb_req", 32'(dmem_req), 32'd0);
    chk("rb_stall", 32'(stall_m), 32'd0);
    chk("rb_rw", 32'(reg_write_m), 32'd0);
    chk("rb_alu", alu_out_m, 32'd0);
    chk("rb_wr", 32'(write_reg_m), 32'd0);
    chk("rb_be", 32'(dmem_be), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("rb_late_ack_rdata", read_data_m, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      int t;
      t   = $urandom_range(0, 2);
      rw  = (t == 1) ? 1'b1 : ((t == 0) ? 1'($urandom % 2) : 1'b0);
      mtr = (t == 1);
      mw  = (t == 2);
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom % 2);
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((sz == 2'd0) ? 32'd0 : (sz == 2'd1) ? 32'd1 : 32'd3);
      ackd = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
      do_op("rnd", rw, mtr, mw, sz, uns, a, $urandom, 5'($urandom), ackd, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
